// File: rtl/count_unit.sv
// Run/stop/clear decimal counter driven by ASCII commands over valid/ready; feeds the FND display.
// Optional COUNT_DOWN_EN: dir=1 makes each tick decrement, wrapping 0 -> MAX_COUNT.
module count_unit #(
    parameter int unsigned DIV_TICK      = 10_000_000,
    parameter int unsigned MAX_COUNT     = 9_999,
    parameter int unsigned WIDTH_COUNTER = $clog2(MAX_COUNT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [7:0]               cmd_data,
    output logic                     cmd_ready,
    input  logic                     dir,
    output logic [WIDTH_COUNTER-1:0] count,
    output logic                     running,
    output logic                     rollover
);

    localparam int unsigned PrescWidth = $clog2(DIV_TICK);
    localparam logic [PrescWidth-1:0]    PrescLast = PrescWidth'(DIV_TICK - 1);
    localparam logic [WIDTH_COUNTER-1:0] CountMax  = WIDTH_COUNTER'(MAX_COUNT);

    localparam logic [7:0] CmdRun    = 8'h52;
    localparam logic [7:0] CmdStop   = 8'h53;
    localparam logic [7:0] CmdClear  = 8'h43;
    localparam logic [7:0] CmdToggle = 8'h54;

    typedef enum logic [1:0] {StStop, StRun, StClear} state_e;

    state_e                   state_q, state_d;
    logic [PrescWidth-1:0]    presc_q, presc_d;
    logic [WIDTH_COUNTER-1:0] count_q, count_d;
    logic                     rollover_q, rollover_d;
    logic                     accept;
    logic                     tick;
    logic                     count_down;

`ifdef COUNT_DOWN_EN
    assign count_down = dir;
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign count_down = 1'b0;
`endif

    assign cmd_ready = (state_q != StClear);
    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (state_q == StRun) && (presc_q == PrescLast);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        count_d    = count_q;
        rollover_d = 1'b0;

        unique case (state_q)
            StStop: begin
                if (accept) begin
                    case (cmd_data)
                        CmdRun, CmdToggle: state_d = StRun;
                        CmdClear:          state_d = StClear;
                        default:           ;
                    endcase
                end
            end
            StRun: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (count_down) begin
                        if (count_q == '0) begin
                            count_d    = CountMax;
                            rollover_d = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end else if (count_q == CountMax) begin
                        count_d    = '0;
                        rollover_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (accept) begin
                    case (cmd_data)
                        CmdStop, CmdToggle: state_d = StStop;
                        CmdClear:           state_d = StClear;
                        default:            ;
                    endcase
                end
            end
            StClear: begin
                state_d = StStop;
                count_d = '0;
                presc_d = '0;
            end
            default: state_d = StStop;
        endcase

        // A clear accepted on a tick cycle overrides the step and its rollover.
        if (state_d == StClear) begin
            count_d    = '0;
            presc_d    = '0;
            rollover_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StStop;
            presc_q    <= '0;
            count_q    <= '0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            rollover_q <= rollover_d;
        end
    end

    assign count    = count_q;
    assign running  = (state_q == StRun);
    assign rollover = rollover_q;

endmodule

// File: tb/tb_count_unit.sv
// Scoreboard bench for count_unit: a driver pushes model predictions, a monitor pops and compares.
module tb_count_unit;

    localparam int unsigned DIV = 4;
    localparam int unsigned MAX = 9_999;
    localparam int unsigned W   = $clog2(MAX);
`ifdef COUNT_DOWN_EN
    localparam bit DownEn = 1'b1;
`else
    localparam bit DownEn = 1'b0;
`endif

    localparam logic [7:0] ChR = 8'h52;
    localparam logic [7:0] ChS = 8'h53;
    localparam logic [7:0] ChC = 8'h43;
    localparam logic [7:0] ChT = 8'h54;
    localparam logic [7:0] ChX = 8'h78;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [7:0]   cmd_data = 8'h00;
    logic         dir = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] count;
    logic         running;
    logic         rollover;

    count_unit #(
        .DIV_TICK  (DIV),
        .MAX_COUNT (MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .dir       (dir),
        .count     (count),
        .running   (running),
        .rollover  (rollover)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit run;
        bit roll;
        bit rdy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: run flag, phase within the tick period, count value.
    bit m_run, m_clear, m_roll;
    int m_phase, m_cnt;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    function automatic void model_reset();
        m_run   = 1'b0;
        m_clear = 1'b0;
        m_roll  = 1'b0;
        m_phase = 0;
        m_cnt   = 0;
    endfunction

    function automatic void model_advance(input bit v, input logic [7:0] d, input bit dn);
        bit acc;
        bit nrun;
        acc    = v && !m_clear;
        m_roll = 1'b0;
        if (m_clear) begin
            m_clear = 1'b0;
            m_run   = 1'b0;
            m_cnt   = 0;
            m_phase = 0;
            return;
        end
        if (acc && d == ChC) begin
            m_clear = 1'b1;
            m_run   = 1'b0;
            m_cnt   = 0;
            m_phase = 0;
            return;
        end
        nrun = m_run;
        if (acc) begin
            if (d == ChR) nrun = 1'b1;
            else if (d == ChS) nrun = 1'b0;
            else if (d == ChT) nrun = !m_run;
        end
        if (m_run) begin
            m_phase++;
            if (m_phase == DIV) begin
                m_phase = 0;
                if (DownEn && dn) begin
                    m_roll = (m_cnt == 0);
                    m_cnt  = (m_cnt == 0) ? MAX : m_cnt - 1;
                end else begin
                    m_roll = (m_cnt == MAX);
                    m_cnt  = (m_cnt + 1) % (MAX + 1);
                end
            end
        end
        m_run = nrun;
    endfunction

    // Called at posedge+2: drive, predict the state after the next edge, then advance one cycle.
    task automatic step(input bit v, input logic [7:0] d, input bit dn);
        exp_t e;
        cmd_valid = v;
        cmd_data  = d;
        dir       = dn;
        model_advance(v, d, dn);
        e.cnt  = m_cnt;
        e.run  = m_run;
        e.roll = m_roll;
        e.rdy  = !m_clear;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit dn);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, dn);
    endtask

    task automatic check_reset_outputs();
        chk("reset_count", int'(count), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_rollover", int'(rollover), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("count", int'(count), e.cnt);
            chk("running", int'(running), int'(e.run));
            chk("rollover", int'(rollover), int'(e.roll));
            chk("cmd_ready", int'(cmd_ready), int'(e.rdy));
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        logic [7:0] d;

        #3;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Run for three steps, stop with a partial period, resume.
        step(1'b1, ChR, 1'b0);
        idle(12, 1'b0);
        idle(1, 1'b0);
        step(1'b1, ChS, 1'b0);
        idle(20, 1'b0);
        step(1'b1, ChR, 1'b0);
        idle(4, 1'b0);

        // Clear on a tick cycle, then a non-command byte.
        n = 0;
        while (!(m_run && m_phase == DIV - 1) && n < 10) begin
            idle(1, 1'b0);
            n++;
        end
        chk("reach_tick_cycle", int'(m_run && m_phase == DIV - 1), 1);
        step(1'b1, ChC, 1'b0);
        step(1'b1, ChX, 1'b0);
        idle(3, 1'b0);

        // From count=1, run with dir=1 (down when the feature is built in).
        step(1'b1, ChR, 1'b0);
        idle(4, 1'b0);
        chk("model_at_one", m_cnt, 1);
        idle(12, 1'b1);
        step(1'b1, ChS, 1'b0);

        // Asynchronous reset mid-run.
        step(1'b1, ChT, 1'b0);
        idle(6, 1'b0);
        do_reset();

        // Randomised commands, including lowercase and arbitrary bytes.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0: d = ChR;
                1: d = ChS;
                2: d = ChC;
                3: d = ChT;
                4: d = ChX;
                5: d = 8'h72;
                6: d = ChR;
                default: d = 8'($urandom);
            endcase
            step(($urandom_range(0, 3) == 0), d, 1'($urandom));
        end

        // Full count up to the wrap-around.
        step(1'b1, ChC, 1'b0);
        idle(1, 1'b0);
        step(1'b1, ChR, 1'b0);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 45_000) begin
            idle(1, 1'b0);
            seen = m_roll;
            n++;
        end
        chk("rollover_reached", int'(seen), 1);
        idle(6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
